// File: rtl/output_port_allocator.sv
// output_port_allocator: wormhole switch allocator for a 5-port mesh router
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_valid    input i holds a flit
//   in_flit_id  head-flit id of input i, field [i*FLIT_ID_W +: FLIT_ID_W]
//   in_req      route request of input i, field [i*NPORTS +: NPORTS], bit o = output o
//   out_ready   output o's downstream can accept a flit
//   in_ready    pop strobe for input i (its flit transfers this cycle)
//   out_valid   output o carries a valid flit
//   out_sel     crossbar select of output o, field [o*SEL_W +: SEL_W]
//   out_busy    output o is locked to a packet
module output_port_allocator #(
    parameter int NPORTS = 5,
    parameter int SEL_W = 3,
    parameter int FLIT_ID_W = 3,
    parameter logic [FLIT_ID_W-1:0] HEADER = 3'b001,
    parameter logic [FLIT_ID_W-1:0] TAIL = 3'b100
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NPORTS-1:0]           in_valid,
    input  logic [NPORTS*FLIT_ID_W-1:0] in_flit_id,
    input  logic [NPORTS*NPORTS-1:0]    in_req,
    input  logic [NPORTS-1:0]           out_ready,
    output logic [NPORTS-1:0]           in_ready,
    output logic [NPORTS-1:0]           out_valid,
    output logic [NPORTS*SEL_W-1:0]     out_sel,
    output logic [NPORTS-1:0]           out_busy
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state [NPORTS];
    state_t                 state_nx [NPORTS];
    logic [SEL_W-1:0]       owner [NPORTS];
    logic [SEL_W-1:0]       owner_nx [NPORTS];
    logic [SEL_W-1:0]       rr_ptr [NPORTS];
    logic [SEL_W-1:0]       rr_nx [NPORTS];
    logic [FLIT_ID_W-1:0]   flit_id [NPORTS];
    logic [NPORTS-1:0]      req [NPORTS];
    logic [NPORTS-1:0]      cand [NPORTS];
    logic [NPORTS-1:0]      locked_in;

    always_comb begin
        locked_in = '0;
        for (int o = 0; o < NPORTS; o++)
            if (state[o] == LOCKED) locked_in[owner[o]] = 1'b1;
    end

    // An input competes only with a HEADER, only for the lowest requested output,
    // and only while it holds no lock, so it can never own two outputs.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            flit_id[i] = in_flit_id[i*FLIT_ID_W +: FLIT_ID_W];
            req[i] = in_req[i*NPORTS +: NPORTS];
            cand[i] = (in_valid[i] && flit_id[i] == HEADER && !locked_in[i]) ? (req[i] & (-req[i])) : '0;
        end
    end

    always_comb begin
        logic found;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        idx = '0;
        in_ready = '0;
        out_valid = '0;
        out_busy = '0;
        out_sel = '0;
        for (int o = 0; o < NPORTS; o++) begin
            state_nx[o] = state[o];
            owner_nx[o] = owner[o];
            rr_nx[o] = rr_ptr[o];
            out_sel[o*SEL_W +: SEL_W] = owner[o];
            if (state[o] == LOCKED) begin
                out_busy[o] = 1'b1;
                out_valid[o] = in_valid[owner[o]] & out_ready[o];
                if (out_valid[o]) begin
                    in_ready[owner[o]] = 1'b1;
                    if (flit_id[owner[o]] == TAIL) state_nx[o] = IDLE;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < NPORTS; k++) begin
                    idx = SEL_W'((int'(rr_ptr[o]) + k) % NPORTS);
                    if (!found && cand[idx][o]) begin
                        found = 1'b1;
                        state_nx[o] = LOCKED;
                        owner_nx[o] = idx;
                        rr_nx[o] = SEL_W'((int'(idx) + 1) % NPORTS);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NPORTS; o++) begin
                state[o] <= IDLE;
                owner[o] <= '0;
                rr_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                state[o] <= state_nx[o];
                owner[o] <= owner_nx[o];
                rr_ptr[o] <= rr_nx[o];
            end
        end
    end
endmodule

// File: tb/tb_output_port_allocator.sv
// tb_output_port_allocator: scoreboard bench for the wormhole switch allocator
module tb_output_port_allocator;
    localparam logic [2:0] H = 3'b001, B = 3'b010, T = 3'b100;

    typedef struct {
        string      tag;
        logic [4:0] ir;
        logic [4:0] ov;
        logic [4:0] ob;
        logic [14:0] sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_valid;
    logic [14:0] in_flit_id;
    logic [24:0] in_req;
    logic [4:0]  out_ready;
    logic [4:0]  in_ready;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;
    logic [4:0]  out_busy;

    logic [2:0]  fid [5];
    logic [4:0]  rq [5];
    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always_comb
        for (int i = 0; i < 5; i++) begin
            in_flit_id[i*3 +: 3] = fid[i];
            in_req[i*5 +: 5] = rq[i];
        end

    output_port_allocator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit_id(in_flit_id), .in_req(in_req),
        .out_ready(out_ready), .in_ready(in_ready), .out_valid(out_valid), .out_sel(out_sel),
        .out_busy(out_busy)
    );

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] sl(input int o, input int v);
        return 15'(v) << (3 * o);
    endfunction

    task automatic set_in(input int i, input logic v, input logic [2:0] id, input logic [4:0] r);
        in_valid[i] = v;
        fid[i] = id;
        rq[i] = r;
    endtask

    task automatic clear_in();
        for (int i = 0; i < 5; i++) set_in(i, 1'b0, 3'b000, 5'b00000);
        out_ready = 5'b11111;
    endtask

    // Select fields of idle outputs carry no meaning, so they are masked out.
    task automatic sb_compare();
        exp_t e;
        logic [14:0] mask;
        e = sb.pop_front();
        mask = '0;
        for (int o = 0; o < 5; o++) if (e.ob[o]) mask |= sl(o, 7);
        check({e.tag, ".in_ready"}, 15'(in_ready), 15'(e.ir));
        check({e.tag, ".out_valid"}, 15'(out_valid), 15'(e.ov));
        check({e.tag, ".out_busy"}, 15'(out_busy), 15'(e.ob));
        check({e.tag, ".out_sel"}, out_sel & mask, e.sel);
    endtask

    task automatic step(input string tag, input logic [4:0] ir, ov, ob, input logic [14:0] sel);
        sb.push_back('{tag, ir, ov, ob, sel});
        @(negedge clk);
        sb_compare();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b0;
        set_in(4, 1'b1, H, 5'b00010);
        #2;
        sb.push_back('{"reset", 5'b0, 5'b0, 5'b0, 15'b0});
        sb_compare();
        @(posedge clk);
        #1;
        step("reset_held", 5'b0, 5'b0, 5'b0, 15'b0);
        rst = 1'b1;

        // 1: L -> E, three-flit packet, bubble after tail
        step("t1_arb", 5'b0, 5'b0, 5'b0, 15'b0);
        step("t1_head", 5'b10000, 5'b00010, 5'b00010, sl(1, 4));
        set_in(4, 1'b1, B, 5'b00010);
        step("t1_body", 5'b10000, 5'b00010, 5'b00010, sl(1, 4));
        set_in(4, 1'b1, T, 5'b00010);
        step("t1_tail", 5'b10000, 5'b00010, 5'b00010, sl(1, 4));
        set_in(4, 1'b0, T, 5'b00010);
        step("t1_idle", 5'b0, 5'b0, 5'b0, 15'b0);

        // 2: N and W contend for S; N first, W after one bubble, then rr_ptr=3 favours L over N
        set_in(0, 1'b1, H, 5'b01000);
        set_in(2, 1'b1, H, 5'b01000);
        step("t2_arb", 5'b0, 5'b0, 5'b0, 15'b0);
        step("t2_n_head", 5'b00001, 5'b01000, 5'b01000, sl(3, 0));
        set_in(0, 1'b1, T, 5'b01000);
        step("t2_n_tail", 5'b00001, 5'b01000, 5'b01000, sl(3, 0));
        set_in(0, 1'b0, T, 5'b01000);
        step("t2_bubble", 5'b0, 5'b0, 5'b0, 15'b0);
        step("t2_w_head", 5'b00100, 5'b01000, 5'b01000, sl(3, 2));
        set_in(2, 1'b1, T, 5'b01000);
        step("t2_w_tail", 5'b00100, 5'b01000, 5'b01000, sl(3, 2));
        set_in(2, 1'b0, T, 5'b01000);
        set_in(0, 1'b1, H, 5'b01000);
        set_in(4, 1'b1, H, 5'b01000);
        step("t2_arb2", 5'b0, 5'b0, 5'b0, 15'b0);
        step("t2_rr_l", 5'b10000, 5'b01000, 5'b01000, sl(3, 4));
        do_reset();

        // 3: E owns S, downstream stalls with TAIL at head
        set_in(1, 1'b1, H, 5'b01000);
        step("t3_arb", 5'b0, 5'b0, 5'b0, 15'b0);
        step("t3_head", 5'b00010, 5'b01000, 5'b01000, sl(3, 1));
        set_in(1, 1'b1, T, 5'b01000);
        out_ready = 5'b10111;
        for (int c = 0; c < 4; c++) step("t3_stall", 5'b0, 5'b0, 5'b01000, sl(3, 1));
        out_ready = 5'b11111;
        step("t3_tail", 5'b00010, 5'b01000, 5'b01000, sl(3, 1));
        set_in(1, 1'b0, T, 5'b01000);
        step("t3_idle", 5'b0, 5'b0, 5'b0, 15'b0);

        // 4: five disjoint routes lock in the same cycle
        set_in(0, 1'b1, H, 5'b00010);
        set_in(1, 1'b1, H, 5'b00100);
        set_in(2, 1'b1, H, 5'b01000);
        set_in(3, 1'b1, H, 5'b00001);
        set_in(4, 1'b1, H, 5'b10000);
        step("t4_arb", 5'b0, 5'b0, 5'b0, 15'b0);
        step("t4_all", 5'b11111, 5'b11111, 5'b11111, sl(0, 3) | sl(1, 0) | sl(2, 1) | sl(3, 2) | sl(4, 4));
        do_reset();

        // 5: async reset mid-packet; orphan BODY ignored; rr_ptr back to 0
        set_in(2, 1'b1, H, 5'b00010);
        step("t5_arb", 5'b0, 5'b0, 5'b0, 15'b0);
        set_in(2, 1'b1, B, 5'b00010);
        #2;
        rst = 1'b0;
        #1;
        sb.push_back('{"t5_async", 5'b0, 5'b0, 5'b0, 15'b0});
        sb_compare();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("t5_orphan", 5'b0, 5'b0, 5'b0, 15'b0);
        set_in(2, 1'b0, B, 5'b00010);
        set_in(0, 1'b1, H, 5'b00010);
        set_in(4, 1'b1, H, 5'b00010);
        step("t5_arb2", 5'b0, 5'b0, 5'b0, 15'b0);
        step("t5_rr0", 5'b00001, 5'b00010, 5'b00010, sl(1, 0));
        do_reset();

        // 6: multi-bit request uses lowest bit; empty request never granted
        set_in(0, 1'b1, H, 5'b00110);
        set_in(1, 1'b1, H, 5'b00000);
        step("t6_arb", 5'b0, 5'b0, 5'b0, 15'b0);
        step("t6_low", 5'b00001, 5'b00010, 5'b00010, sl(1, 0));
        step("t6_hold", 5'b00001, 5'b00010, 5'b00010, sl(1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
